// File: rtl/wb_port_arbiter.sv
// Writeback port arbiter: the pipeline owns the integer/FP register-file write ports, and FPU results queue behind it.
// Optional same-cycle FPU bypass of an empty queue is enabled by defining WB_BYPASS_EN.
module wb_port_arbiter #(
    parameter int XLEN         = 32,
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     pipe_wen,
    input  logic [4:0]               pipe_rd,
    input  logic [XLEN-1:0]          pipe_wdata,
    input  logic                     pipe_fwen,
    input  logic [4:0]               pipe_frd,
    input  logic [XLEN-1:0]          pipe_fwdata,
    input  logic                     fpu_valid,
    output logic                     fpu_ready,
    input  logic                     fpu_is_int,
    input  logic [4:0]               fpu_rd,
    input  logic [XLEN-1:0]          fpu_wdata,
    output logic                     rf_wen,
    output logic [4:0]               rf_rd,
    output logic [XLEN-1:0]          rf_wdata,
    output logic                     frf_wen,
    output logic [4:0]               frf_rd,
    output logic [XLEN-1:0]          frf_wdata,
    output logic                     pipe_stall,
    output logic [$clog2(DEPTH):0]   pend_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam int EW = 1 + 5 + XLEN;

    typedef enum logic [0:0] {
        S_RUN,
        S_STALL
    } state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   starve_cnt, starve_cnt_nxt;

    logic [EW-1:0]   mem [DEPTH];
    logic [AW-1:0]   wptr, rptr, wptr_inc;
    logic            full, empty;

    logic            head_int;
    logic [4:0]      head_rd;
    logic [XLEN-1:0] head_data;

    logic            pipe_i_claim, pipe_f_claim;
    logic            pop, push, accept, drop, byp;

    assign empty    = !full && (wptr == rptr);
    assign wptr_inc = wptr + AW'(1);
    assign {head_int, head_rd, head_data} = mem[rptr];

    assign pipe_stall = (state == S_STALL);

    // During the forced stall the pipeline's requests are ignored so the head is guaranteed the port.
    assign pipe_i_claim = pipe_wen && (pipe_rd != 5'd0) && !pipe_stall;
    assign pipe_f_claim = pipe_fwen && !pipe_stall;

    assign pop       = !empty && (head_int ? !pipe_i_claim : !pipe_f_claim);
    assign fpu_ready = !full || pop;
    assign accept    = fpu_valid && fpu_ready;
    assign drop      = fpu_is_int && (fpu_rd == 5'd0);

`ifdef WB_BYPASS_EN
    assign byp = accept && !drop && empty && (fpu_is_int ? !pipe_i_claim : !pipe_f_claim);
`else
    assign byp = 1'b0;
`endif

    assign push     = accept && !drop && !byp;
    assign pend_cnt = {full, wptr - rptr};

    always_comb begin
        rf_wen    = 1'b0;
        rf_rd     = 5'd0;
        rf_wdata  = '0;
        frf_wen   = 1'b0;
        frf_rd    = 5'd0;
        frf_wdata = '0;
        if (pipe_i_claim) begin
            rf_wen   = 1'b1;
            rf_rd    = pipe_rd;
            rf_wdata = pipe_wdata;
        end else if (pop && head_int) begin
            rf_wen   = 1'b1;
            rf_rd    = head_rd;
            rf_wdata = head_data;
        end else if (byp && fpu_is_int) begin
            rf_wen   = 1'b1;
            rf_rd    = fpu_rd;
            rf_wdata = fpu_wdata;
        end
        if (pipe_f_claim) begin
            frf_wen   = 1'b1;
            frf_rd    = pipe_frd;
            frf_wdata = pipe_fwdata;
        end else if (pop && !head_int) begin
            frf_wen   = 1'b1;
            frf_rd    = head_rd;
            frf_wdata = head_data;
        end else if (byp && !fpu_is_int) begin
            frf_wen   = 1'b1;
            frf_rd    = fpu_rd;
            frf_wdata = fpu_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= {fpu_is_int, fpu_rd, fpu_wdata};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
            full <= 1'b0;
        end else begin
            if (push) begin
                wptr <= wptr_inc;
            end
            if (pop) begin
                rptr <= rptr + AW'(1);
            end
            if (push && !pop && (wptr_inc == rptr)) begin
                full <= 1'b1;
            end else if (pop && !push) begin
                full <= 1'b0;
            end
        end
    end

    // Starvation watchdog: counts cycles the head sits blocked, then forces a one-cycle stall.
    always_comb begin
        state_nxt      = state;
        starve_cnt_nxt = starve_cnt;
        case (state)
            S_RUN: begin
                if (!empty && !pop) begin
                    if (starve_cnt == CW'(STARVE_LIMIT - 1)) begin
                        state_nxt = S_STALL;
                    end
                    starve_cnt_nxt = starve_cnt + CW'(1);
                end else begin
                    starve_cnt_nxt = '0;
                end
            end
            S_STALL: begin
                starve_cnt_nxt = '0;
                state_nxt      = S_RUN;
            end
            default: begin
                starve_cnt_nxt = '0;
                state_nxt      = S_RUN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_RUN;
            starve_cnt <= '0;
        end else begin
            state      <= state_nxt;
            starve_cnt <= starve_cnt_nxt;
        end
    end

endmodule
